// File: rtl/scroll_text_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : scroll_text_pkg
//  Purpose  : Shared constants and types for the scrolling text engine.
//             - ASCII codes for blank, backspace and delete.
//             - Window-fetch FSM state encoding.
//             - Falling-edge pattern used by the strobe and clear detectors.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package scroll_text_pkg;

   localparam logic [7:0] ASCII_BLANK = 8'h20;
   localparam logic [7:0] ASCII_BS    = 8'h08;
   localparam logic [7:0] ASCII_DEL   = 8'h7F;

   // {previous, current} synchronised level; 2'b10 is a high-to-low transition
   localparam logic [1:0] EDGE_FALL   = 2'b10;
   localparam logic       SYNC_INIT   = 1'b0;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FETCH  = 2'd1,
      ST_COMMIT = 2'd2
   } win_state_e;

   // Backspace and delete both remove the last stored character
   function automatic logic is_erase(input logic [7:0] c);
      return (c == ASCII_BS) || (c == ASCII_DEL);
   endfunction

endpackage
`default_nettype wire

// File: rtl/char_store.sv
`default_nettype none
// ============================================================================
//  Module   : char_store
//  Purpose  : Simple dual-port character RAM, one write port and one
//             registered read port, written so it maps onto block RAM.
//  Ports    : clk       - clock
//             we_i      - write enable
//             waddr_i   - write address
//             wdata_i   - write data
//             raddr_i   - read address (data valid the following cycle)
//             rdata_o   - registered read data
//  Revision : 1.0  initial release
// ============================================================================
module char_store #(
   parameter int DEPTH     = 256,
   parameter int ADDR_BITS = 8
) (
   input  logic                 clk,
   input  logic                 we_i,
   input  logic [ADDR_BITS-1:0] waddr_i,
   input  logic [7:0]           wdata_i,
   input  logic [ADDR_BITS-1:0] raddr_i,
   output logic [7:0]           rdata_o
);

   logic [7:0] mem_q [DEPTH];
   logic [7:0] rdata_q;

   // No reset: contents survive rstn, and a reset would block RAM inference
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/scroll_text_engine.sv
`default_nettype none
// ============================================================================
//  Module   : scroll_text_engine
//  Purpose  : Stores strobed ASCII bytes in a circular character store and
//             drives NUM_DIGITS character outputs. Text that fits is shown
//             static and left-justified; longer text scrolls left with a
//             GAP-wide blank run before wrapping. Frames are fetched into a
//             shadow buffer and committed in one cycle so no torn frame is
//             ever visible.
//  Ports    : clk, rstn (async active-low)
//             ascii        - byte to store, sampled on detected strobe edge
//             dsn          - active-low async strobe, falling edge = write
//             clearn       - active-low async clear, falling edge = clear
//             pause        - hold scroll position
//             digits       - characters, MSB byte is the leftmost digit
//             len          - number of stored characters
//             full / empty - store occupancy flags
//             scroll_tick  - one-cycle pulse per scroll period
//  Revision : 1.0  initial release
// ============================================================================
module scroll_text_engine
   import scroll_text_pkg::*;
#(
   parameter int NUM_DIGITS      = 4,
   parameter int STORE_DEPTH     = 256,
   parameter int STORE_BITS      = 8,
   parameter int SCROLL_DIV_BITS = 22,
   parameter int GAP             = 4
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic [7:0]              ascii,
   input  logic                    dsn,
   input  logic                    clearn,
   input  logic                    pause,
   output logic [8*NUM_DIGITS-1:0] digits,
   output logic [STORE_BITS:0]     len,
   output logic                    full,
   output logic                    empty,
   output logic                    scroll_tick
);

   localparam int LW = STORE_BITS + 1;              // len / pos width
   localparam int XW = STORE_BITS + 2;              // len+GAP without overflow
   localparam int IW = $clog2(NUM_DIGITS + 1);      // fetch index 0..NUM_DIGITS
   localparam int SW = $clog2(NUM_DIGITS);          // shadow slot index

   localparam logic [LW-1:0] LEN_ONE  = LW'(1);
   localparam logic [LW-1:0] LEN_FULL = LW'(STORE_DEPTH);
   localparam logic [LW-1:0] ND_LEN   = LW'(NUM_DIGITS);
   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS);

   // ---------------- input synchronisers and edge detect ----------------
   logic dsn_s1_q, dsn_s2_q, dsn_prev_q;
   logic clr_s1_q, clr_s2_q, clr_prev_q;
   logic write_ev, clear_ev;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         dsn_s1_q   <= SYNC_INIT;
         dsn_s2_q   <= SYNC_INIT;
         dsn_prev_q <= SYNC_INIT;
         clr_s1_q   <= SYNC_INIT;
         clr_s2_q   <= SYNC_INIT;
         clr_prev_q <= SYNC_INIT;
      end else begin
         dsn_s1_q   <= dsn;
         dsn_s2_q   <= dsn_s1_q;
         dsn_prev_q <= dsn_s2_q;
         clr_s1_q   <= clearn;
         clr_s2_q   <= clr_s1_q;
         clr_prev_q <= clr_s2_q;
      end
   end

   assign write_ev = ({dsn_prev_q, dsn_s2_q} == EDGE_FALL);
   assign clear_ev = ({clr_prev_q, clr_s2_q} == EDGE_FALL);

   // ---------------- scroll tick divider ----------------
   logic [SCROLL_DIV_BITS-1:0] tick_cnt_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) tick_cnt_q <= '0;
      else       tick_cnt_q <= tick_cnt_q + SCROLL_DIV_BITS'(1);
   end

   assign scroll_tick = &tick_cnt_q;

   // ---------------- length, store write, position ----------------
   logic [LW-1:0] len_q, len_d, pos_q, pos_d;
   logic [XW-1:0] lim_w;
   logic          we_w, dirty_set_w;

   assign full  = (len_q == LEN_FULL);
   assign empty = (len_q == '0);
   assign len   = len_q;

   always_comb begin
      len_d = len_q;
      we_w  = 1'b0;
      if (clear_ev) begin
         len_d = '0;
      end else if (write_ev) begin
         if (is_erase(ascii)) begin
            if (len_q != '0) len_d = len_q - LEN_ONE;
         end else if (!full) begin
            we_w  = 1'b1;
            len_d = len_q + LEN_ONE;
         end
      end
   end

   // Last valid scroll position for the length that takes effect this cycle,
   // so a shrinking length clamps pos on the same cycle it changes.
   assign lim_w = {1'b0, len_d} + XW'(GAP) - XW'(1);

   always_comb begin
      pos_d = pos_q;
      if (clear_ev || (len_d <= ND_LEN)) begin
         pos_d = '0;
      end else if ({1'b0, pos_q} > lim_w) begin
         pos_d = '0;
      end else if (scroll_tick && !pause) begin
         pos_d = ({1'b0, pos_q} == lim_w) ? '0 : pos_q + LEN_ONE;
      end
   end

   assign dirty_set_w = we_w || clear_ev || (len_d != len_q) || (pos_d != pos_q);

   // ---------------- window fetch FSM ----------------
   win_state_e                 state_q, state_d;
   logic [IW-1:0]              idx_q, idx_d;
   logic [LW-1:0]              pos_snap_q, pos_snap_d, len_snap_q, len_snap_d;
   logic                       dirty_q, dirty_d, latch_w;
   logic [7:0]                 shadow_q [NUM_DIGITS];
   logic [7:0]                 shadow_d [NUM_DIGITS];
   logic [8*NUM_DIGITS-1:0]    digits_q, digits_d;
   logic [STORE_BITS-1:0]      raddr_w;
   logic [7:0]                 rdata_w;
   logic [XW-1:0]              slot_pos_w;
   logic [SW-1:0]              slot_w;

   // Read issued at index i lands one cycle later, i.e. while idx_q = i+1
   assign raddr_w    = pos_snap_q[STORE_BITS-1:0] + STORE_BITS'(idx_q);
   assign slot_pos_w = {1'b0, pos_snap_q} + XW'(idx_q) - XW'(1);
   assign slot_w     = SW'(idx_q - IW'(1));

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      pos_snap_d = pos_snap_q;
      len_snap_d = len_snap_q;
      shadow_d   = shadow_q;
      digits_d   = digits_q;
      latch_w    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (dirty_q) begin
               latch_w    = 1'b1;
               pos_snap_d = pos_q;
               len_snap_d = len_q;
               idx_d      = '0;
               state_d    = ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (idx_q != '0) begin
               shadow_d[slot_w] = (slot_pos_w >= {1'b0, len_snap_q}) ? ASCII_BLANK : rdata_w;
            end
            if (idx_q == IDX_LAST) state_d = ST_COMMIT;
            else                   idx_d   = idx_q + IW'(1);
         end
         ST_COMMIT: begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
               digits_d[8*(NUM_DIGITS-1-k) +: 8] = shadow_q[k];
            end
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // A new change arriving on the latch cycle (or during FETCH/COMMIT) wins
   // over the clear, so it is serviced on the next pass through IDLE.
   assign dirty_d = (dirty_q && !latch_w) || dirty_set_w;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         len_q      <= '0;
         pos_q      <= '0;
         dirty_q    <= 1'b0;
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         pos_snap_q <= '0;
         len_snap_q <= '0;
         shadow_q   <= '{default: ASCII_BLANK};
         digits_q   <= {NUM_DIGITS{ASCII_BLANK}};
      end else begin
         len_q      <= len_d;
         pos_q      <= pos_d;
         dirty_q    <= dirty_d;
         state_q    <= state_d;
         idx_q      <= idx_d;
         pos_snap_q <= pos_snap_d;
         len_snap_q <= len_snap_d;
         shadow_q   <= shadow_d;
         digits_q   <= digits_d;
      end
   end

   assign digits = digits_q;

   char_store #(
      .DEPTH     (STORE_DEPTH),
      .ADDR_BITS (STORE_BITS)
   ) u_store (
      .clk     (clk),
      .we_i    (we_w),
      .waddr_i (len_q[STORE_BITS-1:0]),
      .wdata_i (ascii),
      .raddr_i (raddr_w),
      .rdata_o (rdata_w)
   );

endmodule
`default_nettype wire

// File: tb/tb_scroll_text_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_scroll_text_engine
//  Purpose  : Directed self-checking bench for scroll_text_engine with
//             NUM_DIGITS=4, STORE_DEPTH=16, SCROLL_DIV_BITS=3, GAP=4.
//  Revision : 1.0  initial release
// ============================================================================
module tb_scroll_text_engine;

   localparam int ND = 4;
   localparam int SB = 4;

   logic          clk = 1'b0;
   logic          rstn;
   logic [7:0]    ascii;
   logic          dsn, clearn, pause;
   logic [8*ND-1:0] digits;
   logic [SB:0]   len;
   logic          full, empty, scroll_tick;

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   scroll_text_engine #(
      .NUM_DIGITS      (ND),
      .STORE_DEPTH     (16),
      .STORE_BITS      (SB),
      .SCROLL_DIV_BITS (3),
      .GAP             (4)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .ascii       (ascii),
      .dsn         (dsn),
      .clearn      (clearn),
      .pause       (pause),
      .digits      (digits),
      .len         (len),
      .full        (full),
      .empty       (empty),
      .scroll_tick (scroll_tick)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Strobe one byte: low for two cycles, then high long enough to re-arm
   task automatic write_char(input logic [7:0] c);
      ascii = c;
      dsn   = 1'b0;
      repeat (2) @(negedge clk);
      dsn   = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic write_str(input string s);
      for (int i = 0; i < s.len(); i++) write_char(s[i]);
   endtask

   task automatic do_clear();
      clearn = 1'b0;
      repeat (2) @(negedge clk);
      clearn = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic settle();
      repeat (12) @(negedge clk);
   endtask

   // Advance to the next negedge where scroll_tick is high; the window shown
   // there reflects the position set by the previous tick.
   task automatic tick_sample();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!scroll_tick && n < 64);
      check("tick_seen", {63'd0, scroll_tick}, 64'd1);
   endtask

   logic [31:0] scroll_tbl [11];

   initial begin
      scroll_tbl[0]  = "LLO ";
      scroll_tbl[1]  = "LO  ";
      scroll_tbl[2]  = "O   ";
      scroll_tbl[3]  = "    ";
      scroll_tbl[4]  = "    ";
      scroll_tbl[5]  = "    ";
      scroll_tbl[6]  = "    ";
      scroll_tbl[7]  = "HELL";
      scroll_tbl[8]  = "ELLO";
      scroll_tbl[9]  = "LLO ";
      scroll_tbl[10] = "LO  ";

      rstn = 1'b0; dsn = 1'b1; clearn = 1'b1; pause = 1'b0; ascii = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_digits", {32'd0, digits}, {32'd0, 32'h20202020});
      check("rst_len",    {59'd0, len},    64'd0);
      check("rst_empty",  {63'd0, empty},  64'd1);
      check("rst_full",   {63'd0, full},   64'd0);
      check("rst_tick",   {63'd0, scroll_tick}, 64'd0);
      rstn = 1'b1;
      repeat (4) @(negedge clk);

      // ---- static text ----
      write_str("AB");
      settle();
      check("ab_digits", {32'd0, digits}, {32'd0, "AB  "});
      check("ab_len",    {59'd0, len},    64'd2);
      check("ab_empty",  {63'd0, empty},  64'd0);
      tick_sample();
      tick_sample();
      check("ab_static", {32'd0, digits}, {32'd0, "AB  "});

      // ---- scrolling, pause, wrap ----
      pause = 1'b1;
      do_clear();
      write_str("HELLO");
      settle();
      check("hello_len",  {59'd0, len},    64'd5);
      check("hello_pos0", {32'd0, digits}, {32'd0, "HELL"});
      tick_sample();
      pause = 1'b0;                       // this tick moves to pos 1
      tick_sample();
      check("hello_pos1", {32'd0, digits}, {32'd0, "ELLO"});
      pause = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick_sample();
         check("pause_hold", {32'd0, digits}, {32'd0, "ELLO"});
      end
      pause = 1'b0;
      for (int i = 0; i < 11; i++) begin
         tick_sample();
         check("scroll_win", {32'd0, digits}, {32'd0, scroll_tbl[i]});
      end
      pause = 1'b1;                       // hold at pos 3

      // ---- shrink clamps position ----
      write_char(8'h08);
      write_char(8'h7F);
      settle();
      check("clamp_len",    {59'd0, len},    64'd3);
      check("clamp_digits", {32'd0, digits}, {32'd0, "HEL "});
      pause = 1'b0;
      tick_sample();
      tick_sample();
      check("clamp_static", {32'd0, digits}, {32'd0, "HEL "});

      // ---- full store ----
      do_clear();
      for (int i = 0; i < 16; i++) write_char(8'h61 + 8'(i));
      settle();
      check("full_len",  {59'd0, len},   64'd16);
      check("full_flag", {63'd0, full},  64'd1);
      write_char("Z");
      settle();
      check("drop_len",  {59'd0, len},   64'd16);
      check("drop_full", {63'd0, full},  64'd1);
      write_char(8'h08);
      settle();
      check("bs_len",    {59'd0, len},   64'd15);
      check("bs_full",   {63'd0, full},  64'd0);

      // ---- clear and strobe on the same cycle ----
      ascii  = "Q";
      dsn    = 1'b0;
      clearn = 1'b0;
      repeat (2) @(negedge clk);
      dsn    = 1'b1;
      clearn = 1'b1;
      settle();
      check("clrw_len",    {59'd0, len},    64'd0);
      check("clrw_empty",  {63'd0, empty},  64'd1);
      check("clrw_digits", {32'd0, digits}, {32'd0, 32'h20202020});

      // ---- reset during FETCH ----
      pause = 1'b1;
      write_str("AB");
      settle();
      check("pre_rst_digits", {32'd0, digits}, {32'd0, "AB  "});
      ascii = "C";
      dsn   = 1'b0;
      repeat (2) @(negedge clk);
      dsn   = 1'b1;
      repeat (3) @(negedge clk);          // FSM now partway through FETCH
      rstn  = 1'b0;
      #1;
      check("midrst_digits", {32'd0, digits}, {32'd0, 32'h20202020});
      check("midrst_empty",  {63'd0, empty},  64'd1);
      check("midrst_len",    {59'd0, len},    64'd0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      repeat (4) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/scroll_text_engine.md
Name: scroll_text_engine

Overview:
Parametrised successor to the four-digit scrolling display controller. Accepts strobed ASCII bytes into an on-chip circular character store of STORE_DEPTH entries and drives NUM_DIGITS character outputs.
- Text that fits is shown static and left-justified.
- Longer text scrolls left with a blank gap before wrapping.
- Adds pause, an explicit full flag, and an atomic window-fetch FSM so digits never show a torn frame.
- Sits between the host byte interface and four_char_display (or a wider successor).

Parameters:
NUM_DIGITS, 4, number of character outputs (>=2)
STORE_DEPTH, 256, character store entries (power of 2)
STORE_BITS, 8, log2(STORE_DEPTH)
SCROLL_DIV_BITS, 22, scroll tick period is 2^SCROLL_DIV_BITS clk cycles
GAP, 4, blank positions shown after last char before wrap (1..NUM_DIGITS)

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
ascii  in  8  byte to store; sampled when strobe edge detected
dsn  in  1  active-low data strobe, asynchronous level; 2-flop synchronised, falling edge = one write
clearn  in  1  active-low clear, 2-flop synchronised, falling edge = one clear
pause  in  1  high holds scroll position (ticks ignored)
digits  out  8*NUM_DIGITS  chars, digits[8*NUM_DIGITS-1 -: 8] = leftmost
len  out  STORE_BITS+1  characters stored
full  out  1  len == STORE_DEPTH
empty  out  1  len == 0
scroll_tick  out  1  one-cycle pulse per scroll period (debug/LED)

Behaviour:
- Reset (async, rstn low): len=0, full=0, empty=1, pos=0, every digit=8'h20, tick counter=0, FSM=IDLE, dirty=0, sync flops=0. Store contents are not cleared.
- Strobe: write_ev = sync'd falling edge of dsn, one per strobe regardless of width. ascii is sampled on the same cycle the edge is detected.
- Write rules:
  - ascii 8'h08 or 8'h7F: len-1 if len!=0, else ignored.
  - Other bytes with !full: store[len]<=ascii, len+1.
  - Other bytes with full: dropped, state unchanged.
- Any store/len change sets dirty.
- Clear: clear_ev sets len=0 and pos=0 and sets dirty. clear_ev beats a write_ev in the same cycle.
- Tick: free-running SCROLL_DIV_BITS counter; scroll_tick=1 when counter is all ones.
- Position update on tick (pause=0, len>NUM_DIGITS): pos<=(pos==len+GAP-1)?0:pos+1, then set dirty. When len<=NUM_DIGITS, pos is forced to 0.
- Clamp: if len shrinks so pos>len+GAP-1, pos<=0 on the same cycle as the len update.
- Window FSM, states IDLE, FETCH, COMMIT:
  - IDLE: if dirty, latch pos_snap=pos and len_snap=len, clear dirty, i=0 -> FETCH.
  - FETCH: issue store read addr=(pos_snap+i) mod STORE_DEPTH; sync read returns one cycle later into shadow[i-1]. Slot i is blank (8'h20) when pos_snap+i>=len_snap. i runs 0..NUM_DIGITS; leave after the last data returns.
  - COMMIT: copy shadow to digits in one cycle -> IDLE.
  - Latency from dirty to digits update: NUM_DIGITS+3 cycles.
  - dirty set during FETCH/COMMIT is kept and serviced on the next IDLE; no event is lost.
- Static mode: len<=NUM_DIGITS gives pos=0, chars left-justified, trailing blanks.
- Width: pos is STORE_BITS+1 bits; len+GAP is computed at STORE_BITS+2 bits so there is no overflow at full.
- Reset mid-FETCH: abort immediately, all digits blank.

Decomposition:
- Package scroll_text_pkg holds:
  - ASCII_BLANK=8'h20, ASCII_BS=8'h08, ASCII_DEL=8'h7F
  - FSM state encoding (2 bits)
  - edge-detect helper constants
- Sub-module char_store: simple dual-port RAM, 1 write port / 1 sync read port, DEPTH and ADDR_BITS parameters, so it infers block RAM.
- Tick divider is inline (a counter, not the existing clock_gen, so there is no derived clock).

Test Plan:
(Bench params: NUM_DIGITS=4, STORE_DEPTH=16, SCROLL_DIV_BITS=3, GAP=4.)
- Write "AB" -> within 7 cycles digits={"A","B",20h,20h}, len=2, no change on ticks.
- Write "HELLO" -> sequence of windows over ticks:
  - "HELL", "ELLO", "LLO_", "LO__", "O___", "____", then "HELL" again.
  - Period is 9 ticks.
- Write 16 chars then one more -> full=1, len=16, 17th dropped. Backspace -> full=0, len=15.
- Scroll "HELLO" to pos=3, then backspace x2 -> len=3, pos clamped to 0, digits="HEL_".
- Assert pause during "HELLO" scroll at "ELLO" -> window held for 5 ticks, resumes to "LLO_".
- Same-cycle clear and strobe -> len=0 and digits all 20h. Also pull rstn low mid-FETCH -> digits 20h immediately, empty=1.
